wbs_mem_ctrl: RTL and testbench

//  Wishbone slave front-end for the KD-tree ANN accelerator. Decodes host accesses into control

---
 rtl/fieldious_wbs_pkg.sv | 45 ++++
 rtl/wbs_addr_decode.sv | 40 ++++
 rtl/wbs_mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_wbs_mem_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fieldious_wbs_pkg.sv
// Shared types and constants for the KD-tree accelerator Wishbone slave front-end.
package fieldious_wbs_pkg;

  typedef enum logic [1:0] {
    REG_QUERY = 2'd0,
    REG_LEAF  = 2'd1,
    REG_BEST  = 2'd2,
    REG_NODE  = 2'd3
  } region_e;

  localparam logic [31:0] WBS_ADDR_MASK = 32'hFFFF_0000;
  localparam logic [31:0] CTRL_BASE     = 32'h3000_0000;
  localparam logic [31:0] QUERY_BASE    = 32'h3001_0000;
  localparam logic [31:0] LEAF_BASE     = 32'h3002_0000;
  localparam logic [31:0] BEST_BASE     = 32'h3003_0000;
  localparam logic [31:0] NODE_BASE     = 32'h3004_0000;

  localparam logic [7:0] OFS_MODE   = 8'h00;
  localparam logic [7:0] OFS_DEBUG  = 8'h04;
  localparam logic [7:0] OFS_DONE   = 8'h08;
  localparam logic [7:0] OFS_START  = 8'h0C;
  localparam logic [7:0] OFS_STATUS = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ACCESS,
    ST_RWAIT,
    ST_ACK
  } state_e;

  // What the latched access turned into once decoded and arbitrated.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CTRL,
    ACT_START,
    ACT_MEMWR,
    ACT_MEMRD
  } action_e;

  function automatic logic regionHit(input logic [31:0] adr, input logic [31:0] base);
    return (adr & WBS_ADDR_MASK) == base;
  endfunction

endpackage

// File: rtl/wbs_addr_decode.sv
// Combinational decode of the upper byte-address half into control, memory region or unmapped.
module wbs_addr_decode
  import fieldious_wbs_pkg::*;
(
  input  logic [15:0] adr_hi_i,
  output logic        is_ctrl_o,
  output logic        is_mem_o,
  output region_e     region_o,
  output logic        unmapped_o
);

  logic [31:0] fullAdr;

  assign fullAdr = {adr_hi_i, 16'h0000};

  always_comb begin
    is_ctrl_o  = 1'b0;
    is_mem_o   = 1'b0;
    region_o   = REG_QUERY;
    unmapped_o = 1'b0;
    if (regionHit(fullAdr, CTRL_BASE)) begin
      is_ctrl_o = 1'b1;
    end else if (regionHit(fullAdr, QUERY_BASE)) begin
      is_mem_o = 1'b1;
      region_o = REG_QUERY;
    end else if (regionHit(fullAdr, LEAF_BASE)) begin
      is_mem_o = 1'b1;
      region_o = REG_LEAF;
    end else if (regionHit(fullAdr, BEST_BASE)) begin
      is_mem_o = 1'b1;
      region_o = REG_BEST;
    end else if (regionHit(fullAdr, NODE_BASE)) begin
      is_mem_o = 1'b1;
      region_o = REG_NODE;
    end else begin
      unmapped_o = 1'b1;
    end
  end

endmodule

// File: rtl/wbs_mem_ctrl.sv
// Wishbone slave front-end: control registers, 32->64 bit write packing, SRAM read sequencing.
// Define WBS_READBACK_EN to make query/leaf/node regions host-readable (default: best only).
module wbs_mem_ctrl
  import fieldious_wbs_pkg::*;
#(
  parameter int          MEM_ADDR_W = 13,
  parameter int          MEM_DATA_W = 64,
  parameter logic [31:0] ERR_RDATA  = 32'h0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [1:0]            mem_region_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [MEM_DATA_W-1:0] mem_wdata_o,
  input  logic [MEM_DATA_W-1:0] mem_rdata_i,
  output logic                  host_own_o,
  output logic                  fsm_start_o,
  input  logic                  fsm_busy_i,
  input  logic                  fsm_done_i,
  output logic                  mode_o,
  output logic                  debug_o
);

  state_e      state_q, state_d;
  action_e     act_q, act_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [31:0] staging_q, staging_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mode_q, mode_d;
  logic        debug_q, debug_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        hostOwn_q;
  logic        errSet, errClr, doneClr;

  logic        isCtrl, isMem, unmapped, readable;
  region_e     region;
  logic        memActive, memWrite;
  logic [63:0] wdataFull;
  logic        unused_ok;

  wbs_addr_decode u_decode (
    .adr_hi_i   (adr_q[31:16]),
    .is_ctrl_o  (isCtrl),
    .is_mem_o   (isMem),
    .region_o   (region),
    .unmapped_o (unmapped)
  );

`ifdef WBS_READBACK_EN
  assign readable = 1'b1;
`else
  assign readable = (region == REG_BEST);
`endif

  assign unused_ok = ^{wbs_sel_i, adr_q[1:0], unmapped};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      act_q     <= ACT_NONE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      staging_q <= '0;
      rdata_q   <= '0;
      mode_q    <= 1'b0;
      debug_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      hostOwn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      staging_q <= staging_d;
      rdata_q   <= rdata_d;
      mode_q    <= mode_d;
      debug_q   <= debug_d;
      done_q    <= done_d;
      err_q     <= err_d;
      hostOwn_q <= ~fsm_busy_i;
    end
  end

  // Arbitration and register side effects are resolved in DECODE, so a busy edge
  // arriving later never cancels an access that has already been committed.
  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    staging_d = staging_q;
    rdata_d   = rdata_q;
    mode_d    = mode_q;
    debug_d   = debug_q;
    errSet    = 1'b0;
    errClr    = 1'b0;
    doneClr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          adr_d   = wbs_adr_i;
          dat_d   = wbs_dat_i;
          we_d    = wbs_we_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_ACCESS;
        act_d   = ACT_NONE;
        rdata_d = ERR_RDATA;
        if (isCtrl) begin
          act_d = ACT_CTRL;
          if (we_q) begin
            case (adr_q[7:0])
              OFS_MODE:   mode_d  = dat_q[0];
              OFS_DEBUG:  debug_d = dat_q[0];
              OFS_DONE:   doneClr = dat_q[0];
              OFS_START: begin
                if (fsm_busy_i) errSet = 1'b1;
                else            act_d  = ACT_START;
              end
              OFS_STATUS: errClr  = dat_q[1];
              default: ;
            endcase
          end else begin
            case (adr_q[7:0])
              OFS_MODE:   rdata_d = {31'b0, mode_q};
              OFS_DEBUG:  rdata_d = {31'b0, debug_q};
              OFS_DONE:   rdata_d = {31'b0, done_q};
              OFS_STATUS: rdata_d = {30'b0, err_q, fsm_busy_i};
              default: ;
            endcase
          end
        end else if (isMem) begin
          if (we_q) begin
            if (region != REG_NODE && !adr_q[2]) begin
              staging_d = dat_q;
            end else if (region == REG_NODE && adr_q[2]) begin
              act_d = ACT_NONE;
            end else if (fsm_busy_i) begin
              errSet = 1'b1;
            end else begin
              act_d = ACT_MEMWR;
            end
          end else if (readable) begin
            if (fsm_busy_i) errSet = 1'b1;
            else            act_d  = ACT_MEMRD;
          end
        end
      end
      ST_ACCESS: begin
        state_d = (act_q == ACT_MEMRD) ? ST_RWAIT : ST_ACK;
      end
      ST_RWAIT: begin
        rdata_d = adr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = fsm_done_i | (done_q & ~doneClr);
    err_d  = errSet | (err_q & ~errClr);
  end

  assign memActive = (state_q == ST_ACCESS) && (act_q == ACT_MEMWR || act_q == ACT_MEMRD);
  assign memWrite  = (state_q == ST_ACCESS) && (act_q == ACT_MEMWR);
  assign wdataFull = (region == REG_NODE) ? {32'h0, dat_q} : {dat_q, staging_q};

  assign wbs_ack_o    = (state_q == ST_ACK);
  assign wbs_dat_o    = wbs_ack_o ? rdata_q : '0;
  assign mem_req_o    = memActive;
  assign mem_we_o     = memWrite;
  assign mem_region_o = memActive ? region : 2'b00;
  assign mem_addr_o   = memActive ? MEM_ADDR_W'(adr_q[15:3]) : '0;
  assign mem_wdata_o  = memWrite ? MEM_DATA_W'(wdataFull) : '0;
  assign fsm_start_o  = (state_q == ST_ACCESS) && (act_q == ACT_START);
  assign host_own_o   = hostOwn_q;
  assign mode_o       = mode_q;
  assign debug_o      = debug_q;

endmodule

// File: tb/tb_wbs_mem_ctrl.sv
// Directed scoreboard bench for wbs_mem_ctrl: memory transactions are predicted into a queue
// and retired by a monitor; bus read data and ack latency are checked per access.
module tb_wbs_mem_ctrl;

  typedef struct {
    logic        we;
    logic [1:0]  region;
    logic [12:0] addr;
    logic [63:0] wdata;
  } memTxn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, datIn = '0;
  logic        ack;
  logic [31:0] datOut;
  logic        memReq, memWe;
  logic [1:0]  memRegion;
  logic [12:0] memAddr;
  logic [63:0] memWdata;
  logic [63:0] memRdata = '0;
  logic        hostOwn, fsmStart, mode, debug;
  logic        busy = 1'b0, done = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          startCount = 0;
  memTxn_t     expQ[$];

  wbs_mem_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_stb_i    (stb),
    .wbs_cyc_i    (cyc),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (datIn),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (datOut),
    .mem_req_o    (memReq),
    .mem_we_o     (memWe),
    .mem_region_o (memRegion),
    .mem_addr_o   (memAddr),
    .mem_wdata_o  (memWdata),
    .mem_rdata_i  (memRdata),
    .host_own_o   (hostOwn),
    .fsm_start_o  (fsmStart),
    .fsm_busy_i   (busy),
    .fsm_done_i   (done),
    .mode_o       (mode),
    .debug_o      (debug)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Retire predicted memory transactions in order; any unpredicted request is an error.
  always @(negedge clk) begin
    memTxn_t t;
    if (memReq === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_mem_req", 64'd1, 64'd0);
      end else begin
        t = expQ.pop_front();
        checkOutput("mem_we", {63'b0, memWe}, {63'b0, t.we});
        checkOutput("mem_region", {62'b0, memRegion}, {62'b0, t.region});
        checkOutput("mem_addr", {51'b0, memAddr}, {51'b0, t.addr});
        checkOutput("mem_wdata", memWdata, t.wdata);
      end
    end
    if (fsmStart === 1'b1) startCount++;
  end

  // One classic Wishbone access; lat = edges from the sampling edge k to the ack-raising edge.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rdata, output int lat);
    bit got = 0;
    rdata = '0;
    lat   = -1;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; datIn = d;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        got = 1;
        lat = n - 1;
        rdata = datOut;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) checkOutput("ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    checkOutput("ack_one_cycle", {63'b0, ack}, 64'd0);
  endtask

  task automatic doWrite(input string tag, input logic [31:0] a, input logic [31:0] d, input int expLat);
    logic [31:0] r;
    int l;
    applyStimulus(1'b1, a, d, r, l);
    checkOutput({tag, "_lat"}, 64'(l), 64'(expLat));
  endtask

  task automatic doRead(input string tag, input logic [31:0] a, input logic [31:0] expDat, input int expLat);
    logic [31:0] r;
    int l;
    applyStimulus(1'b0, a, 32'h0, r, l);
    checkOutput({tag, "_dat"}, {32'b0, r}, {32'b0, expDat});
    checkOutput({tag, "_lat"}, 64'(l), 64'(expLat));
  endtask

  initial begin
    int s0;
    logic [31:0] r;
    int l;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ack", {63'b0, ack}, 64'd0);
    checkOutput("rst_mem_req", {63'b0, memReq}, 64'd0);
    checkOutput("rst_start", {63'b0, fsmStart}, 64'd0);
    checkOutput("rst_mode", {63'b0, mode}, 64'd0);
    checkOutput("rst_host_own", {63'b0, hostOwn}, 64'd0);
    checkOutput("rst_dat_o", {32'b0, datOut}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("host_own_idle", {63'b0, hostOwn}, 64'd1);

    $display("[TB] control registers");
    doWrite("mode_wr", 32'h3000_0000, 32'h1, 2);
    checkOutput("mode_o", {63'b0, mode}, 64'd1);
    doRead("mode_rd", 32'h3000_0000, 32'h1, 2);
    doWrite("debug_wr", 32'h3000_0004, 32'h1, 2);
    checkOutput("debug_o", {63'b0, debug}, 64'd1);
    doRead("status_idle", 32'h3000_0010, 32'h0, 2);

    $display("[TB] packed writes");
    doWrite("leaf_lo", 32'h3002_0008, 32'hAAAA_5555, 2);
    expQ.push_back('{1'b1, 2'd1, 13'd1, 64'h0000_1234_AAAA_5555});
    doWrite("leaf_hi", 32'h3002_000C, 32'h0000_1234, 2);
    expQ.push_back('{1'b1, 2'd3, 13'd3, 64'h0000_0000_0037_0801});
    doWrite("node_wr", 32'h3004_0018, 32'h0037_0801, 2);
    doWrite("node_hi_ignored", 32'h3004_001C, 32'hDEAD_BEEF, 2);

    $display("[TB] reads");
    memRdata = 64'h0000_0123_0000_0456;
    expQ.push_back('{1'b0, 2'd2, 13'd2, 64'h0});
    doRead("best_lo", 32'h3003_0010, 32'h0000_0456, 3);
    expQ.push_back('{1'b0, 2'd2, 13'd2, 64'h0});
    doRead("best_hi", 32'h3003_0014, 32'h0000_0123, 3);
`ifdef WBS_READBACK_EN
    expQ.push_back('{1'b0, 2'd0, 13'd1, 64'h0});
    doRead("query_rd", 32'h3001_0008, 32'h0000_0456, 3);
`else
    doRead("query_rd_off", 32'h3001_0008, 32'h0, 2);
`endif
    doRead("unmapped_rd", 32'h4000_0000, 32'h0, 2);
    doWrite("unmapped_wr", 32'h4000_0004, 32'h1234_5678, 2);
    doRead("status_no_err", 32'h3000_0010, 32'h0, 2);

    $display("[TB] arbitration");
    busy = 1'b1;
    @(posedge clk); #1;
    checkOutput("host_own_busy", {63'b0, hostOwn}, 64'd0);
    doWrite("query_refused", 32'h3001_000C, 32'h1111_2222, 2);
    doRead("status_err", 32'h3000_0010, 32'h3, 2);
    doRead("best_refused", 32'h3003_0010, 32'h0, 2);
    s0 = startCount;
    doWrite("start_busy", 32'h3000_000C, 32'h1, 2);
    checkOutput("start_busy_pulses", 64'(startCount - s0), 64'd0);
    busy = 1'b0;
    doWrite("status_w1c", 32'h3000_0010, 32'h2, 2);
    doRead("status_cleared", 32'h3000_0010, 32'h0, 2);

    $display("[TB] start and done");
    s0 = startCount;
    doWrite("start_idle", 32'h3000_000C, 32'h1, 2);
    checkOutput("start_pulses", 64'(startCount - s0), 64'd1);
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    doRead("done_set", 32'h3000_0008, 32'h1, 2);
    doRead("done_sticky", 32'h3000_0008, 32'h1, 2);
    doWrite("done_w1c", 32'h3000_0008, 32'h1, 2);
    doRead("done_cleared", 32'h3000_0008, 32'h0, 2);
    // done pulse lands on the same edge as the W1C commit
    fork
      applyStimulus(1'b1, 32'h3000_0008, 32'h1, r, l);
      begin
        @(posedge clk); @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
      end
    join
    doRead("done_set_wins", 32'h3000_0008, 32'h1, 2);

    $display("[TB] reset mid-access");
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3001_000C; datIn = 32'h5555_6666;
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_ack", {63'b0, ack}, 64'd0);
    checkOutput("midrst_req", {63'b0, memReq}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_mode", {63'b0, mode}, 64'd0);
    expQ.push_back('{1'b1, 2'd0, 13'd0, 64'h0000_0077_0000_0000});
    doWrite("staging_reset", 32'h3001_0004, 32'h0000_0077, 2);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
